control_path: RTL and testbench
===============================

CONTROL_PATH -- requirements
Module: control_path

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear on i_rst_n low without waiting for a clock edge.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_opcode  input  7  instruction bits [6:0].
REQ-005 i_f3  input  3  funct3, instruction bits [14:12].
REQ-006 i_f7_bit6  input  1  instruction bit 30 (funct7 bit 5), selects SUB.
REQ-007 i_zero  input  1  ALU zero flag for the current instruction.
REQ-008 o_res_src  output  2  writeback select: 00 ALU result, 01 memory read data, 10 PC+4, 11 unused.
REQ-009 o_pc_src  output  2  next-PC select: 00 PC+4, 01 PC+imm, 10 and 11 unused.
REQ-010 o_alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; other codes unused.
REQ-011 o_reg_wr  output  1  register-file write enable.
REQ-012 o_mem_wr  output  1  data-memory write enable.
REQ-013 o_imm_ctl  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-014 o_alu_src_b  output  1  ALU operand B: 0 register rs2, 1 immediate.
REQ-015 o_illegal  output  1  sticky flag: an illegal instruction was decoded since reset.
REQ-016 o_ret_cnt  output  16  count of clock edges with a legal decoded instruction.

Function
REQ-017 All decode outputs (REQ-008 to REQ-014) SHALL be combinational from the inputs with zero-cycle latency.
REQ-018 R-type (0110011) SHALL decode as: reg_wr=1, mem_wr=0, res_src=00, pc_src=00, alu_src_b=0, imm_ctl=00.
REQ-019 R-type funct3 SHALL map as: 000 gives ADD if f7_bit6=0 and SUB if f7_bit6=1; 010 gives SLT; 110 gives OR; 111 gives AND.
REQ-020 I-type ALU (0010011) SHALL decode as: reg_wr=1, mem_wr=0, res_src=00, pc_src=00, alu_src_b=1, imm_ctl=00.
REQ-021 I-type funct3 SHALL map as: 000 ADD, 010 SLT, 110 OR, 111 AND; f7_bit6 is ignored and SUB is never produced.
REQ-022 lw (0000011) SHALL decode as: reg_wr=1, mem_wr=0, res_src=01, alu_src_b=1, imm_ctl=00, alu_op=ADD, pc_src=00.
REQ-023 sw (0100011) SHALL decode as: reg_wr=0, mem_wr=1, alu_src_b=1, imm_ctl=01, alu_op=ADD, pc_src=00, res_src=00.
REQ-024 beq (1100011, f3=000) SHALL decode as: reg_wr=0, mem_wr=0, alu_src_b=0, imm_ctl=10, alu_op=SUB, res_src=00, and pc_src=01 if i_zero=1, else 00.
REQ-025 jal (1101111) SHALL decode as: reg_wr=1, mem_wr=0, res_src=10, pc_src=01, imm_ctl=11, alu_src_b=1, alu_op=ADD; i_zero is ignored.
REQ-026 An instruction SHALL be illegal when it has any other opcode, an unlisted funct3 for R-type or I-type ALU, or branch funct3 other than 000.
REQ-027 An illegal instruction SHALL decode as: reg_wr=0, mem_wr=0, pc_src=00, res_src=00, alu_op=ADD, alu_src_b=0, imm_ctl=00.
REQ-028 On each rising edge, if the instruction is illegal, o_illegal SHALL set to 1 and stay 1 until reset.
REQ-029 On each rising edge, if the instruction is legal, o_ret_cnt SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-030 While i_rst_n=0, o_reg_wr and o_mem_wr SHALL be forced to 0 and o_pc_src to 00; the other decode outputs follow REQ-017.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately clear o_illegal to 0 and o_ret_cnt to 0, including mid-operation.
REQ-032 The first edge after i_rst_n rises SHALL count or flag normally.

Verification
REQ-033 R-type with f3=000: f7_bit6=0 -> alu_op=000, reg_wr=1, alu_src_b=0; f7_bit6=1 -> alu_op=001.
REQ-034 R-type with f7_bit6=1: f3=010 -> 101; f3=110 -> 011; f3=111 -> 010.
REQ-035 opcode=0010011, f3=111, f7_bit6=1 -> alu_op=010 and alu_src_b=1; lw -> res_src=01; sw -> mem_wr=1, reg_wr=0, imm_ctl=01.
REQ-036 beq with f3=000: zero=0 -> pc_src=00, alu_op=001, imm_ctl=10; zero=1 -> pc_src=01. jal -> res_src=10, pc_src=01, imm_ctl=11, reg_wr=1.
REQ-037 Drive opcode 0000000 for one edge -> o_illegal=1, reg_wr=0, mem_wr=0, and o_ret_cnt holds; apply reset -> o_illegal=0 and o_ret_cnt=0 asynchronously.
REQ-038 Hold a legal R-type for 65537 edges after reset -> o_ret_cnt=0x0001 (wrap); while i_rst_n=0 with a sw opcode -> mem_wr=0.

Source files
------------

// File: rtl/control_path.sv
// rtl/control_path.sv - single-cycle RV32 subset control decoder with retire counter and sticky illegal flag
//
// Ports:
//   i_clk        clock, rising-edge state updates
//   i_rst_n      asynchronous active-low reset
//   i_opcode     instruction [6:0]
//   i_f3         funct3, instruction [14:12]
//   i_f7_bit6    instruction bit 30, distinguishes SUB from ADD for R-type
//   i_zero       ALU zero flag of the current instruction (beq resolution)
//   o_res_src    writeback select: 00 ALU, 01 memory, 10 PC+4
//   o_pc_src     next-PC select: 00 PC+4, 01 PC+imm
//   o_alu_op     000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
//   o_reg_wr     register-file write enable
//   o_mem_wr     data-memory write enable
//   o_imm_ctl    immediate format: 00 I, 01 S, 10 B, 11 J
//   o_alu_src_b  ALU operand B: 0 rs2, 1 immediate
//   o_illegal    sticky: an illegal instruction was seen since reset
//   o_ret_cnt    wrapping count of edges carrying a legal instruction

module control_path (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_f3,
    input  logic        i_f7_bit6,
    input  logic        i_zero,
    output logic [1:0]  o_res_src,
    output logic [1:0]  o_pc_src,
    output logic [2:0]  o_alu_op,
    output logic        o_reg_wr,
    output logic        o_mem_wr,
    output logic [1:0]  o_imm_ctl,
    output logic        o_alu_src_b,
    output logic        o_illegal,
    output logic [15:0] o_ret_cnt
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;

    localparam logic [1:0] IMM_I   = 2'b00;
    localparam logic [1:0] IMM_S   = 2'b01;
    localparam logic [1:0] IMM_B   = 2'b10;
    localparam logic [1:0] IMM_J   = 2'b11;

    // Shared funct3 map for R-type and I-type ALU ops; f3_ok flags the
    // four supported encodings.
    logic [2:0] f3_alu;
    logic       f3_ok;

    always_comb begin
        f3_alu = ALU_ADD;
        f3_ok  = 1'b1;
        case (i_f3)
            3'b000:  f3_alu = ALU_ADD;
            3'b010:  f3_alu = ALU_SLT;
            3'b110:  f3_alu = ALU_OR;
            3'b111:  f3_alu = ALU_AND;
            default: f3_ok  = 1'b0;
        endcase
    end

    logic       legal;
    logic       dec_reg_wr;
    logic       dec_mem_wr;
    logic [1:0] dec_pc_src;

    // Defaults are the illegal-instruction decode, so any path that does
    // not positively recognise an instruction leaves everything inert.
    always_comb begin
        legal       = 1'b0;
        dec_reg_wr  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_pc_src  = PC_SEQ;
        o_res_src   = RES_ALU;
        o_alu_op    = ALU_ADD;
        o_imm_ctl   = IMM_I;
        o_alu_src_b = 1'b0;
        case (i_opcode)
            OP_R: begin
                if (f3_ok) begin
                    legal      = 1'b1;
                    dec_reg_wr = 1'b1;
                    // Only funct3=000 has a SUB variant.
                    if (i_f3 == 3'b000 && i_f7_bit6)
                        o_alu_op = ALU_SUB;
                    else
                        o_alu_op = f3_alu;
                end
            end
            OP_I: begin
                if (f3_ok) begin
                    legal       = 1'b1;
                    dec_reg_wr  = 1'b1;
                    o_alu_src_b = 1'b1;
                    o_alu_op    = f3_alu;
                end
            end
            OP_LW: begin
                legal       = 1'b1;
                dec_reg_wr  = 1'b1;
                o_res_src   = RES_MEM;
                o_alu_src_b = 1'b1;
            end
            OP_SW: begin
                legal       = 1'b1;
                dec_mem_wr  = 1'b1;
                o_alu_src_b = 1'b1;
                o_imm_ctl   = IMM_S;
            end
            OP_BEQ: begin
                if (i_f3 == 3'b000) begin
                    legal      = 1'b1;
                    o_imm_ctl  = IMM_B;
                    o_alu_op   = ALU_SUB;
                    dec_pc_src = i_zero ? PC_IMM : PC_SEQ;
                end
            end
            OP_JAL: begin
                legal       = 1'b1;
                dec_reg_wr  = 1'b1;
                o_res_src   = RES_PC4;
                dec_pc_src  = PC_IMM;
                o_imm_ctl   = IMM_J;
                o_alu_src_b = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Architectural side effects are suppressed while reset is held so a
    // core sitting in reset cannot write state or redirect fetch.
    assign o_reg_wr = dec_reg_wr & i_rst_n;
    assign o_mem_wr = dec_mem_wr & i_rst_n;
    assign o_pc_src = i_rst_n ? dec_pc_src : PC_SEQ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal <= 1'b0;
            o_ret_cnt <= 16'h0000;
        end else if (legal) begin
            o_ret_cnt <= o_ret_cnt + 16'd1;
        end else begin
            o_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_path.sv
// tb/tb_control_path.sv - directed self-checking bench for control_path

module tb_control_path;

    logic        i_clk;
    logic        i_rst_n;
    logic [6:0]  i_opcode;
    logic [2:0]  i_f3;
    logic        i_f7_bit6;
    logic        i_zero;
    logic [1:0]  o_res_src;
    logic [1:0]  o_pc_src;
    logic [2:0]  o_alu_op;
    logic        o_reg_wr;
    logic        o_mem_wr;
    logic [1:0]  o_imm_ctl;
    logic        o_alu_src_b;
    logic        o_illegal;
    logic [15:0] o_ret_cnt;

    int total;
    int bad;

    // Bench-side model of the stateful outputs; exp_legal is set by hand
    // in each scenario for the instruction currently being driven.
    logic        exp_legal;
    logic        exp_ill;
    logic [15:0] exp_cnt;

    // {res_src, pc_src, alu_op, reg_wr, mem_wr, imm_ctl, alu_src_b}
    logic [11:0] ctl;
    assign ctl = {o_res_src, o_pc_src, o_alu_op, o_reg_wr, o_mem_wr, o_imm_ctl, o_alu_src_b};

    control_path dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_opcode    (i_opcode),
        .i_f3        (i_f3),
        .i_f7_bit6   (i_f7_bit6),
        .i_zero      (i_zero),
        .o_res_src   (o_res_src),
        .o_pc_src    (o_pc_src),
        .o_alu_op    (o_alu_op),
        .o_reg_wr    (o_reg_wr),
        .o_mem_wr    (o_mem_wr),
        .o_imm_ctl   (o_imm_ctl),
        .o_alu_src_b (o_alu_src_b),
        .o_illegal   (o_illegal),
        .o_ret_cnt   (o_ret_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z, input logic lg);
        i_opcode  = op;
        i_f3      = f3;
        i_f7_bit6 = f7;
        i_zero    = z;
        exp_legal = lg;
        #1;
    endtask

    // Advance n rising edges, updating the model, ending 1 time unit after the last edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            if (!i_rst_n) begin
                exp_cnt = 16'h0000;
                exp_ill = 1'b0;
            end else if (exp_legal) begin
                exp_cnt = exp_cnt + 16'd1;
            end else begin
                exp_ill = 1'b1;
            end
            #1;
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        drive(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1);
        total++;
        if (o_illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_illegal got=%b want=0", o_illegal);
        end
        total++;
        if (o_ret_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_cnt got=%h want=0000", o_ret_cnt);
        end
    endtask

    task automatic test_reset_gating;
        logic [6:0]  ops  [3] = '{7'b0100011, 7'b0110011, 7'b1101111};
        logic [11:0] want [3] = '{12'b00_00_000_0_0_01_1,
                                  12'b00_00_000_0_0_00_0,
                                  12'b10_00_000_0_0_11_1};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 3'b000, 1'b0, 1'b1, 1'b1);
            total++;
            if (ctl !== want[i]) begin
                bad++;
                $display("FAIL gating_%0d got=%b want=%b", i, ctl, want[i]);
            end
            step(1);
        end
        total++;
        if (o_ret_cnt !== 16'h0000 || o_illegal !== 1'b0) begin
            bad++;
            $display("FAIL gating_state got=%h/%b want=0000/0", o_ret_cnt, o_illegal);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
        logic        f7s  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] want [5] = '{12'b00_00_000_1_0_00_0,
                                  12'b00_00_001_1_0_00_0,
                                  12'b00_00_101_1_0_00_0,
                                  12'b00_00_011_1_0_00_0,
                                  12'b00_00_010_1_0_00_0};
        for (int i = 0; i < 5; i++) begin
            drive(7'b0110011, f3s[i], f7s[i], 1'b0, 1'b1);
            total++;
            if (ctl !== want[i]) begin
                bad++;
                $display("FAIL rtype_%0d got=%b want=%b", i, ctl, want[i]);
            end
            step(1);
        end
        total++;
        if (o_ret_cnt !== 16'd5) begin
            bad++;
            $display("FAIL rtype_cnt got=%0d want=5", o_ret_cnt);
        end
    endtask

    task automatic test_itype_mem;
        logic [6:0]  ops  [6] = '{7'b0010011, 7'b0010011, 7'b0010011,
                                  7'b0010011, 7'b0000011, 7'b0100011};
        logic [2:0]  f3s  [6] = '{3'b111, 3'b000, 3'b010, 3'b110, 3'b010, 3'b010};
        logic [11:0] want [6] = '{12'b00_00_010_1_0_00_1,
                                  12'b00_00_000_1_0_00_1,
                                  12'b00_00_101_1_0_00_1,
                                  12'b00_00_011_1_0_00_1,
                                  12'b01_00_000_1_0_00_1,
                                  12'b00_00_000_0_1_01_1};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], f3s[i], 1'b1, 1'b1, 1'b1);
            total++;
            if (ctl !== want[i]) begin
                bad++;
                $display("FAIL imem_%0d got=%b want=%b", i, ctl, want[i]);
            end
            step(1);
        end
        total++;
        if (o_ret_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL imem_cnt got=%0d want=%0d", o_ret_cnt, exp_cnt);
        end
    endtask

    task automatic test_branch_jump;
        logic [6:0]  ops  [4] = '{7'b1100011, 7'b1100011, 7'b1101111, 7'b1101111};
        logic        zs   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] want [4] = '{12'b00_00_001_0_0_10_0,
                                  12'b00_01_001_0_0_10_0,
                                  12'b10_01_000_1_0_11_1,
                                  12'b10_01_000_1_0_11_1};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 3'b000, 1'b0, zs[i], 1'b1);
            total++;
            if (ctl !== want[i]) begin
                bad++;
                $display("FAIL brjmp_%0d got=%b want=%b", i, ctl, want[i]);
            end
            step(1);
        end
        total++;
        if (o_ret_cnt !== 16'd15 || o_illegal !== 1'b0) begin
            bad++;
            $display("FAIL brjmp_state got=%0d/%b want=15/0", o_ret_cnt, o_illegal);
        end
    endtask

    task automatic test_illegal;
        logic [6:0] ops [4] = '{7'b0000000, 7'b0110011, 7'b0010011, 7'b1100011};
        logic [2:0] f3s [4] = '{3'b000, 3'b001, 3'b100, 3'b001};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], f3s[i], 1'b1, 1'b1, 1'b0);
            total++;
            if (ctl !== 12'b0) begin
                bad++;
                $display("FAIL illegal_dec_%0d got=%b want=%b", i, ctl, 12'b0);
            end
            step(1);
            total++;
            if (o_illegal !== 1'b1 || o_ret_cnt !== 16'd15) begin
                bad++;
                $display("FAIL illegal_state_%0d got=%b/%0d want=1/15", i, o_illegal, o_ret_cnt);
            end
        end
        drive(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1);
        total++;
        if (o_illegal !== 1'b1 || o_ret_cnt !== 16'd16) begin
            bad++;
            $display("FAIL illegal_sticky got=%b/%0d want=1/16", o_illegal, o_ret_cnt);
        end
        // Reset between edges must clear state without a clock.
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_illegal !== 1'b0 || o_ret_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset got=%b/%h want=0/0000", o_illegal, o_ret_cnt);
        end
        exp_cnt = 16'h0000;
        exp_ill = 1'b0;
        #1;
        i_rst_n = 1'b1;
        step(1);
        total++;
        if (o_ret_cnt !== 16'd1) begin
            bad++;
            $display("FAIL first_edge got=%0d want=1", o_ret_cnt);
        end
    endtask

    task automatic test_wrap;
        i_rst_n = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        exp_ill = 1'b0;
        i_rst_n = 1'b1;
        drive(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
        step(65535);
        total++;
        if (o_ret_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_max got=%h want=ffff", o_ret_cnt);
        end
        step(2);
        total++;
        if (o_ret_cnt !== 16'h0001 || o_illegal !== 1'b0) begin
            bad++;
            $display("FAIL wrap got=%h/%b want=0001/0", o_ret_cnt, o_illegal);
        end
        total++;
        if (o_ret_cnt !== exp_cnt || o_illegal !== exp_ill) begin
            bad++;
            $display("FAIL wrap_model got=%h want=%h", o_ret_cnt, exp_cnt);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_legal = 1'b0;
        exp_ill   = 1'b0;
        exp_cnt   = 16'h0000;
        test_reset;
        test_reset_gating;
        test_rtype;
        test_itype_mem;
        test_branch_jump;
        test_illegal;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
